// File: rtl/div16_8_seq_if.sv
// Operand/result handshake bundle for div16_8_seq: valid/ready request side
// carrying dividend/divisor, valid/ready response side carrying the result.
interface div16_8_seq_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             dbz;
    logic             ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz, ovf
    );
endinterface

// File: rtl/div16_8_seq.sv
// Sequential radix-2 restoring divider, 2N-bit dividend / N-bit divisor.
// Define DIV_APPROX_TRUNC_EN to compute only the upper N/2 quotient bits (remainder forced to 0).
module div16_8_seq #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    div16_8_seq_if.slave  bus
);
`ifdef DIV_APPROX_TRUNC_EN
    localparam int ITERS = N / 2;
`else
    localparam int ITERS = N;
`endif
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    // Stored partial remainder is always < divisor, so N bits suffice; the
    // N+1-bit intermediate only exists combinationally as r_shift.
    logic [N-1:0]    rem_q, rem_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N-1:0]    qw_q, qw_d;
    logic [N-1:0]    quo_q, quo_d;
    logic [N-1:0]    rmd_q, rmd_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [N:0]      r_shift;
    logic [N:0]      r_sub;
    logic            q_bit;
    logic [N-1:0]    qw_next;
    logic [N-1:0]    rem_next;

    always_comb begin
        r_shift  = {rem_q, lo_q[N-1]};
        r_sub    = r_shift - {1'b0, dvs_q};
        q_bit    = (r_shift >= {1'b0, dvs_q});
        qw_next  = {qw_q[N-2:0], q_bit};
        rem_next = q_bit ? r_sub[N-1:0] : r_shift[N-1:0];
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        qw_d    = qw_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    rem_d   = bus.dividend[2*N-1:N];
                    lo_d    = bus.dividend[N-1:0];
                    dvs_d   = bus.divisor;
                    qw_d    = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Error cases resolve on the first BUSY edge, one cycle after acceptance.
                if (cnt_q == '0 && dvs_q == '0) begin
                    quo_d   = '1;
                    rmd_d   = lo_q;
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == '0 && rem_q >= dvs_q) begin
                    quo_d   = '1;
                    rmd_d   = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rem_d = rem_next;
                    lo_d  = {lo_q[N-2:0], 1'b0};
                    qw_d  = qw_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITERS - 1)) begin
`ifdef DIV_APPROX_TRUNC_EN
                        quo_d = {qw_next[N/2-1:0], {(N/2){1'b0}}};
                        rmd_d = '0;
`else
                        quo_d = qw_next;
                        rmd_d = rem_next;
`endif
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            qw_q    <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            qw_q    <= qw_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_div16_8_seq.sv
// Scoreboard bench for div16_8_seq: directed corner cases, backpressure,
// asynchronous reset abort and random exact divisions.
module tb_div16_8_seq;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    div16_8_seq_if #(.N(8)) bus ();

    div16_8_seq #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        int   qi;
        int   ri;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (dvs == 8'h00) begin
            e.q = 8'hFF; e.r = dvd[7:0]; e.dbz = 1'b1; e.lat = 1;
        end else if (dvd[15:8] >= dvs) begin
            e.q = 8'hFF; e.r = 8'h00; e.ovf = 1'b1; e.lat = 1;
        end else begin
            qi = int'(dvd) / int'(dvs);
            ri = int'(dvd) % int'(dvs);
`ifdef DIV_APPROX_TRUNC_EN
            e.q = 8'(qi) & 8'hF0; e.r = 8'h00; e.lat = 4;
`else
            e.q = 8'(qi); e.r = 8'(ri); e.lat = 8;
`endif
        end
        return e;
    endfunction

    task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs,
                         input bit bp, input bit prop);
        exp_t e;
        int   lat;
        int   w;
        @(negedge clk);
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        sb.push_back(model(dvd, dvs));
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bus.in_valid = (bp && lat == 2);
        end
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
            return;
        end
        $display("[TB] op %h/%h -> q=%h r=%h dbz=%0d ovf=%0d lat=%0d",
                 dvd, dvs, bus.quotient, bus.remainder, bus.dbz, bus.ovf, lat);
        chk("quotient",  32'(bus.quotient),  32'(e.q));
        chk("remainder", 32'(bus.remainder), 32'(e.r));
        chk("dbz",       32'(bus.dbz),       32'(e.dbz));
        chk("ovf",       32'(bus.ovf),       32'(e.ovf));
        chk("latency",   32'(lat),           32'(e.lat));
`ifndef DIV_APPROX_TRUNC_EN
        if (prop) begin
            chk("identity", 32'(int'(bus.quotient) * int'(dvs) + int'(bus.remainder)), 32'(dvd));
            chk("rem_lt_div", 32'(bus.remainder < dvs), 32'd1);
        end
`endif
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk("bp_hold", {14'd0, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder},
                    {14'd0, 1'b1, 1'b0, e.q, e.r});
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("retire", {22'd0, bus.out_valid, bus.in_ready, bus.quotient},
            {22'd0, 1'b0, 1'b1, e.q});
    endtask

    initial begin
        logic [7:0]  d;
        logic [7:0]  hi;
        logic [15:0] dv;
        bit          seen;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", {20'd0, bus.in_ready, bus.out_valid, bus.dbz, bus.ovf, bus.quotient, bus.remainder},
            {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});

        do_op(16'h3039, 8'h64, 1'b0, 1'b1);
        do_op(16'hFEFF, 8'hFF, 1'b0, 1'b1);
        do_op(16'h1234, 8'h00, 1'b0, 1'b0);
        do_op(16'h6400, 8'h64, 1'b0, 1'b0);
        do_op(16'h0000, 8'h01, 1'b0, 1'b1);
        do_op(16'h3039, 8'h64, 1'b1, 1'b1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        bus.dividend = 16'h3039;
        bus.divisor  = 8'h64;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {20'd0, bus.in_ready, bus.out_valid, bus.dbz, bus.ovf, bus.quotient, bus.remainder},
            {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("no_valid_after_rst", 32'(seen), 32'd0);
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            d  = 8'($urandom_range(1, 255));
            hi = 8'($urandom_range(0, int'(d) - 1));
            dv = {hi, 8'($urandom)};
            do_op(dv, d, 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div16_8_seq.md
Name: div16_8_seq

Overview:
Sequential radix-2 restoring divider. It divides a 2N-bit dividend, the product width of the 8x8 multiplier family, by an N-bit divisor and returns an N-bit quotient and an N-bit remainder. It is the inverse-operation companion to the recursive multipliers and is used to recover operands and to check multiplier error. Input and output each use a valid/ready handshake, and the block accepts one operation at a time.

Parameters:
N, 8, divisor/quotient/remainder width; dividend width is 2N; N must be even.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept an operation
dividend  input  2N  dividend
divisor  input  N  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
quotient  output  N  quotient
remainder  output  N  remainder
dbz  output  1  divide-by-zero flag
ovf  output  1  quotient-overflow flag

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, dbz=0, ovf=0, iteration counter=0.
- Reset mid-operation aborts immediately and discards the operation. No out_valid is produced for it.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Acceptance: on a clk edge in IDLE with in_valid=1, the block latches dividend and divisor.
  - divisor==0: go to DONE. quotient=all ones, remainder=dividend[N-1:0], dbz=1, ovf=0.
  - else if dividend[2N-1:N] >= divisor: go to DONE. quotient=all ones, remainder=0, ovf=1, dbz=0.
  - else: go to BUSY. Partial remainder R (N+1 bits) = dividend[2N-1:N]. Counter=0.
- BUSY, one iteration per cycle, dividend bits N-1 down to 0:
  - R' = {R[N-1:0], next dividend bit}.
  - If R' >= divisor: R = R' - divisor and the quotient bit is 1. Otherwise R = R' and the quotient bit is 0.
  - Quotient bits shift in MSB-first.
  - After the N-th iteration: go to DONE, remainder=R[N-1:0], dbz=0, ovf=0.
- Latency, counted from the accepting edge k:
  - Normal: out_valid=1 after edge k+N (8 cycles).
  - Error (dbz or ovf): out_valid=1 after edge k+1.
- DONE:
  - quotient, remainder, dbz and ovf hold stable while out_valid=1 and out_ready=0.
  - Edge with out_ready=1: go to IDLE, out_valid=0. Result registers keep their last values.
- Simultaneous events: in_valid is ignored outside IDLE. No acceptance occurs in the same cycle as result retirement; the earliest next acceptance is the edge after the return to IDLE.
- Width rule: R never exceeds 2*divisor-1 < 2^(N+1), so N+1 bits are sufficient. The subtraction is N+1 bits wide.
- Operands may change after acceptance without affecting the result.

Optional Feature:
Macro: DIV_APPROX_TRUNC_EN
- Defined:
  - BUSY runs only N/2 iterations, for quotient bits N-1 down to N/2.
  - Quotient low N/2 bits are forced to 0.
  - remainder=0.
  - Normal latency is N/2 cycles (4 at N=8).
  - dbz and ovf handling is unchanged.
- Undefined: exact division as specified above.

Test Plan:
- Exact result: dividend=0x3039, divisor=0x64 -> quotient=0x7B, remainder=0x2D, dbz=0, ovf=0. out_valid rises 8 cycles after acceptance. With DIV_APPROX_TRUNC_EN: quotient=0x70, remainder=0x00, 4 cycles.
- Maximum quotient: dividend=0xFEFF, divisor=0xFF -> quotient=0xFF, remainder=0xFE, ovf=0.
- Divide by zero: dividend=0x1234, divisor=0x00 -> quotient=0xFF, remainder=0x34, dbz=1, out_valid 1 cycle after acceptance.
- Overflow: dividend=0x6400, divisor=0x64 -> ovf=1, quotient=0xFF, remainder=0x00. Also dividend=0x0000, divisor=0x01 -> quotient=0x00, remainder=0x00, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0. Pulse in_valid with new operands during BUSY -> ignored. Assert out_ready -> IDLE next edge, in_ready=1.
- Reset: deassert rst_n asynchronously at iteration 4 of 0x3039/0x64 -> all outputs take reset values immediately, no out_valid. Then run 1000 random exact operations -> quotient*divisor+remainder==dividend and remainder<divisor.
